// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the decode hazard / multiplier sequencing controller.
// Holds the FSM encoding, the zero register and the scoreboard entry layout.
package hazard_ctrl_pkg;

    // Widest register address a scoreboard entry can hold.
    localparam int SB_RD_W  = 8;
    localparam int REG_ZERO = 0;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MUL_BUSY  = 2'd1,
        MUL_ISSUE = 2'd2
    } hz_state_t;

    typedef struct packed {
        logic               valid;
        logic [SB_RD_W-1:0] rd;
    } sb_entry_t;

    function automatic logic rd_match(
        input sb_entry_t          e,
        input logic [SB_RD_W-1:0] rs
    );
        return e.valid && (e.rd != SB_RD_W'(REG_ZERO)) && (e.rd == rs);
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// In-flight destination tracker for EX, MEM and WB.
// Flags a read-after-write hazard against any tracked writer.
module hazard_scoreboard
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int PIPE_DEPTH = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic              id_wr_en,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [REG_AW-1:0] id_rs_a,
    input  logic [REG_AW-1:0] id_rs_b,
    input  logic              id_uses_b,
    input  logic              bubble,
    output logic              raw
);

    sb_entry_t          sb [PIPE_DEPTH];
    sb_entry_t          ld;
    logic [SB_RD_W-1:0] rs_a;
    logic [SB_RD_W-1:0] rs_b;
    logic               hit;

    always_comb begin
        ld.valid = id_valid & id_wr_en & ~bubble
                 & (id_rd != REG_AW'(REG_ZERO));
        ld.rd    = SB_RD_W'(id_rd);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                sb[i] <= '0;
            end
        end else begin
            sb[0] <= ld;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                sb[i] <= sb[i-1];
            end
        end
    end

    assign rs_a = SB_RD_W'(id_rs_a);
    assign rs_b = SB_RD_W'(id_rs_b);

    // WB is included: the register file write and the operand capture
    // happen on the same edge, so the read would see the stale value.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            if (rd_match(sb[i], rs_a)) begin
                hit = 1'b1;
            end
            if (id_uses_b && rd_match(sb[i], rs_b)) begin
                hit = 1'b1;
            end
        end
    end

    assign raw = id_valid & hit;

endmodule

// File: rtl/hazard_ctrl.sv
// Decode sequencing: RAW stall/bubble insertion and multiplier handshake.
// Owns the FSM, watchdog and saturating stall counter.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int PIPE_DEPTH  = 3,
    parameter int MUL_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs_a,
    input  logic [REG_AW-1:0] id_rs_b,
    input  logic              id_uses_b,
    input  logic              id_wr_en,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_is_mul,
    input  logic              mul_done,
    output logic              stall,
    output logic              bubble,
    output logic              mul_start,
    output logic              mul_busy,
    output logic              mul_timeout,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int WD_W = $clog2(MUL_TIMEOUT) + 1;

    hz_state_t         state;
    hz_state_t         state_nxt;
    logic [WD_W-1:0]   wd_cnt;
    logic              raw;
    logic              stall_c;
    logic              bubble_c;
    logic              start_c;
    logic              busy_c;
    logic              wd_clr;
    logic              wd_inc;
    logic              wd_fire;

    hazard_scoreboard #(
        .REG_AW     (REG_AW),
        .PIPE_DEPTH (PIPE_DEPTH)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .id_valid  (id_valid),
        .id_wr_en  (id_wr_en),
        .id_rd     (id_rd),
        .id_rs_a   (id_rs_a),
        .id_rs_b   (id_rs_b),
        .id_uses_b (id_uses_b),
        .bubble    (bubble),
        .raw       (raw)
    );

    assign wd_fire = (wd_cnt == WD_W'(MUL_TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        stall_c   = 1'b0;
        bubble_c  = 1'b0;
        start_c   = 1'b0;
        busy_c    = 1'b0;
        wd_clr    = 1'b0;
        wd_inc    = 1'b0;
        unique case (state)
            IDLE: begin
                if (raw) begin
                    stall_c  = 1'b1;
                    bubble_c = 1'b1;
                end else if (id_valid && id_is_mul) begin
                    start_c   = 1'b1;
                    stall_c   = 1'b1;
                    bubble_c  = 1'b1;
                    wd_clr    = 1'b1;
                    state_nxt = MUL_BUSY;
                end
            end
            MUL_BUSY: begin
                stall_c  = 1'b1;
                bubble_c = 1'b1;
                busy_c   = 1'b1;
                wd_inc   = 1'b1;
                if (mul_done || wd_fire) begin
                    state_nxt = MUL_ISSUE;
                end
            end
            MUL_ISSUE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Gated so a held decode input cannot leak through while in reset.
    assign stall     = rst & stall_c;
    assign bubble    = rst & bubble_c;
    assign mul_start = rst & start_c;
    assign mul_busy  = rst & busy_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt <= '0;
        end else if (wd_clr) begin
            wd_cnt <= '0;
        end else if (wd_inc) begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end

    // Sticky: the late product is garbage and only reset clears the report.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_timeout <= 1'b0;
        end else if (busy_c && wd_fire && !mul_done) begin
            mul_timeout <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: RAW stalls, MUL handshake, watchdog, reset.
// Expected values are hand-derived per scenario.
module tb_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs_a;
    logic [4:0]  id_rs_b;
    logic        id_uses_b;
    logic        id_wr_en;
    logic [4:0]  id_rd;
    logic        id_is_mul;
    logic        mul_done;
    logic        stall;
    logic        bubble;
    logic        mul_start;
    logic        mul_busy;
    logic        mul_timeout;
    logic [15:0] stall_cnt;

    int checks;
    int failures;

    hazard_ctrl #(
        .REG_AW      (5),
        .PIPE_DEPTH  (3),
        .MUL_TIMEOUT (64),
        .CNT_W       (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_rs_a     (id_rs_a),
        .id_rs_b     (id_rs_b),
        .id_uses_b   (id_uses_b),
        .id_wr_en    (id_wr_en),
        .id_rd       (id_rd),
        .id_is_mul   (id_is_mul),
        .mul_done    (mul_done),
        .stall       (stall),
        .bubble      (bubble),
        .mul_start   (mul_start),
        .mul_busy    (mul_busy),
        .mul_timeout (mul_timeout),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] a,
                          input logic [4:0] b, input logic ub,
                          input logic we, input logic [4:0] rd,
                          input logic mul);
        id_valid  = v;
        id_rs_a   = a;
        id_rs_b   = b;
        id_uses_b = ub;
        id_wr_en  = we;
        id_rd     = rd;
        id_is_mul = mul;
    endtask

    task automatic idle(input int n);
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk_sb(input string tag, input logic s,
                          input logic b, input logic st,
                          input logic bz);
        chk({tag, ".stall"}, 32'(stall), 32'(s));
        chk({tag, ".bubble"}, 32'(bubble), 32'(b));
        chk({tag, ".start"}, 32'(mul_start), 32'(st));
        chk({tag, ".busy"}, 32'(mul_busy), 32'(bz));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        mul_done = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        #2;
        chk_sb("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset.timeout", 32'(mul_timeout), 0);
        chk("reset.cnt", 32'(stall_cnt), 0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // ADD r3 then ADD reading r3: three stalls (EX, MEM, WB)
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0);
        #1;
        chk_sb("raw.w", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        set_id(1'b1, 5'd3, 5'd2, 1'b1, 1'b1, 5'd4, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_sb($sformatf("raw.s%0d", i), 1'b1, 1'b1, 1'b0, 1'b0);
            tick();
        end
        #1;
        chk_sb("raw.go", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("raw.cnt", 32'(stall_cnt), 3);
        tick();
        idle(3);

        // r0 never hazards
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd6, 1'b0);
        #1;
        chk("r0.stall", 32'(stall), 0);
        idle(3);

        // r5 in EX, rs_b=5 only hazards when rs_b is used
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b0);
        tick();
        set_id(1'b1, 5'd1, 5'd5, 1'b0, 1'b0, 5'd0, 1'b0);
        #1;
        chk("imm.stall", 32'(stall), 0);
        id_uses_b = 1'b1;
        #1;
        chk("useb.stall", 32'(stall), 1);
        id_valid = 1'b0;
        #1;
        chk("novalid.stall", 32'(stall), 0);
        idle(3);
        chk("cnt.after_r0", 32'(stall_cnt), 3);

        // MUL with clean operands, done on 10th busy cycle
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1);
        #1;
        chk_sb("mul.start", 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        for (int k = 1; k <= 10; k++) begin
            mul_done = (k == 10);
            #1;
            chk_sb($sformatf("mul.b%0d", k), 1'b1, 1'b1, 1'b0, 1'b1);
            tick();
        end
        mul_done = 1'b0;
        #1;
        chk_sb("mul.issue", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mul.cnt", 32'(stall_cnt), 14);
        tick();
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        mul_done = 1'b1;
        #1;
        chk_sb("mul.idle_done", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        mul_done = 1'b0;
        #1;
        chk("mul.ign", 32'(mul_busy), 0);
        idle(3);

        // MUL reading r7 while r7 sits in MEM
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b0);
        tick();
        idle(1);
        set_id(1'b1, 5'd7, 5'd2, 1'b1, 1'b1, 5'd8, 1'b1);
        for (int i = 0; i < 2; i++) begin
            #1;
            chk_sb($sformatf("mulraw.s%0d", i), 1'b1, 1'b1, 1'b0, 1'b0);
            tick();
        end
        #1;
        chk_sb("mulraw.start", 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        mul_done = 1'b1;
        #1;
        chk_sb("mulraw.b1", 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        mul_done = 1'b0;
        #1;
        chk_sb("mulraw.issue", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mulraw.cnt", 32'(stall_cnt), 18);
        tick();
        idle(3);

        // watchdog: mul_done never comes
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd10, 1'b1);
        tick();
        for (int k = 1; k <= 64; k++) begin
            #1;
            if (k == 1 || k == 64) begin
                chk_sb($sformatf("wd.b%0d", k), 1'b1, 1'b1, 1'b0, 1'b1);
                chk($sformatf("wd.flag%0d", k), 32'(mul_timeout), 0);
            end
            tick();
        end
        #1;
        chk_sb("wd.issue", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("wd.flag", 32'(mul_timeout), 1);
        tick();
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        #1;
        chk_sb("wd.idle", 1'b0, 1'b0, 1'b0, 1'b0);
        idle(4);
        chk("wd.sticky", 32'(mul_timeout), 1);
        chk("wd.cnt", 32'(stall_cnt), 83);

        // reset in 5th busy cycle
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd11, 1'b1);
        tick();
        for (int k = 1; k < 5; k++) tick();
        #1;
        chk("rstm.busy_pre", 32'(mul_busy), 1);
        rst = 1'b0;
        #1;
        chk_sb("rstm", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rstm.flag", 32'(mul_timeout), 0);
        chk("rstm.cnt", 32'(stall_cnt), 0);
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        mul_done = 1'b1;
        #1;
        chk_sb("rstm.done", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        mul_done = 1'b0;
        #1;
        chk_sb("rstm.after", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rstm.cnt2", 32'(stall_cnt), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
